// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: ALU codes, opcodes, FSM states and select encodings
// for the multi-cycle RV32 control path (ERROR state with ILLEGAL_TRAP_EN).
package riscv_ctrl_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_BNE  = 4'b0001,
    ALU_JAL  = 4'b0010,
    ALU_JALR = 4'b0011,
    ALU_LUI  = 4'b0100,
    ALU_LBU  = 4'b0101,
    ALU_SB   = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRL  = 4'b1001,
    ALU_XOR  = 4'b1010,
    ALU_OR   = 4'b1011,
    ALU_AND  = 4'b1100,
    ALU_BEQ  = 4'b1101
  } alu_op_e;

  typedef enum logic [1:0] {
    CLS_ADD,
    CLS_R,
    CLS_I,
    CLS_BR
  } alu_cls_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWRITE,
    S_MEMWB,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_JALRPC,
    S_LUI
`ifdef ILLEGAL_TRAP_EN
    , S_ERROR
`endif
  } state_e;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] SRCB_RDATA = 2'b11;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    logic [2:0] sel;
    sel = IMM_I;
    case (op)
      OP_STORE:  sel = IMM_S;
      OP_BRANCH: sel = IMM_B;
      OP_LUI:    sel = IMM_U;
      OP_JAL:    sel = IMM_J;
      default:   sel = IMM_I;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps the instruction class plus funct3/funct7b5
// onto the 4-bit ALUControl code.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] cls,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] alu_control
);

  logic sub;

  assign sub = funct7b5 & (cls == CLS_R);

  // class-driven ALU code selection
  always_comb begin
    alu_control = ALU_ADD;
    unique case (1'b1)
      cls == CLS_BR: begin
        alu_control = (funct3 == 3'b001) ? ALU_BNE : ALU_BEQ;
      end
      cls == CLS_R,
      cls == CLS_I: begin
        case (funct3)
          3'b000:  alu_control = sub ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle RV32 control FSM driving datapath selects.
// ILLEGAL_TRAP_EN: unknown opcodes trap into a sticky ERROR state.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_src,
  output logic [3:0] alu_control,
  output logic       illegal
);

`ifdef ILLEGAL_TRAP_EN
  localparam state_e S_BAD = S_ERROR;
`else
  localparam state_e S_BAD = S_FETCH;
`endif

  state_e     state;
  alu_cls_e   cls;
  logic [3:0] dec_op;
  alu_op_e    code;

  alu_decoder u_dec (
    .cls         (cls),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_control (dec_op)
  );

  // state sequencing; memory states wait for mem_ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      unique case (state)
        S_FETCH: begin
          if (mem_ready) state <= S_DECODE;
        end
        S_DECODE: begin
          case (op)
            OP_LOAD,
            OP_STORE:  state <= S_MEMADR;
            OP_RTYPE:  state <= S_EXECR;
            OP_ITYPE:  state <= S_EXECI;
            OP_BRANCH: state <= S_BRANCH;
            OP_JAL:    state <= S_JAL;
            OP_JALR:   state <= S_JALR;
            OP_LUI:    state <= S_LUI;
            default:   state <= S_BAD;
          endcase
        end
        S_MEMADR: begin
          state <= (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
        end
        S_MEMREAD: begin
          if (mem_ready) state <= S_MEMWB;
        end
        S_MEMWRITE: begin
          if (mem_ready) state <= S_FETCH;
        end
        S_MEMWB,
        S_ALUWB,
        S_BRANCH:   state <= S_FETCH;
        S_EXECR,
        S_EXECI,
        S_JAL,
        S_JALRPC,
        S_LUI:      state <= S_ALUWB;
        S_JALR:     state <= S_JALRPC;
        default:    state <= S_BAD;
      endcase
    end
  end

  // which ALU decode class applies in this state
  always_comb begin
    cls = CLS_ADD;
    unique case (state)
      S_EXECR:  cls = CLS_R;
      S_EXECI:  cls = CLS_I;
      S_BRANCH: cls = CLS_BR;
      default:  cls = CLS_ADD;
    endcase
  end

  // Moore control word; fetch and branch strobes gated by inputs
  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    imm_src    = IMM_I;
    code       = ALU_ADD;
    unique case (state)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURES;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = imm_of(op);
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        if (op == OP_STORE) begin
          imm_src = IMM_S;
          code    = ALU_SB;
        end
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_MEMWB: begin
        alu_src_b  = SRCB_RDATA;
        result_src = RES_ALURES;
        code       = ALU_LBU;
        reg_write  = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        code      = alu_op_e'(dec_op);
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        code      = alu_op_e'(dec_op);
      end
      S_ALUWB: begin
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = SRCA_RS1;
        imm_src   = IMM_B;
        code      = alu_op_e'(dec_op);
        pc_write  = (dec_op == ALU_BNE) ? ~zero : zero;
      end
      S_JAL,
      S_JALRPC: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
      end
      S_JALR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        code      = ALU_JALR;
      end
      S_LUI: begin
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_U;
        code      = ALU_LUI;
      end
      default: begin
        code = ALU_ADD;
      end
    endcase
    if (rst) begin
      pc_write   = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      result_src = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      imm_src    = 3'b000;
      code       = ALU_ADD;
    end
  end

  assign alu_control = code;

`ifdef ILLEGAL_TRAP_EN
  assign illegal = (state == S_ERROR);
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench; a per-instruction cycle model
// pushes expected control words, a negedge monitor compares them.
module tb_multicycle_ctrl;

  localparam int A_ADD  = 0;
  localparam int A_BNE  = 1;
  localparam int A_JALR = 3;
  localparam int A_LUI  = 4;
  localparam int A_LBU  = 5;
  localparam int A_SB   = 6;
  localparam int A_SLL  = 7;
  localparam int A_SUB  = 8;
  localparam int A_SRL  = 9;
  localparam int A_XOR  = 10;
  localparam int A_OR   = 11;
  localparam int A_AND  = 12;
  localparam int A_BEQ  = 13;

  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] JR  = 7'b1100111;
  localparam logic [6:0] LU  = 7'b0110111;

  typedef struct packed {
    logic       pcw;
    logic       irw;
    logic       rw;
    logic       mw;
    logic       adr;
    logic [1:0] res;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [2:0] imm;
    logic [3:0] alu;
    logic       ill;
  } ctl_t;

  typedef struct {
    ctl_t  v;
    ctl_t  m;
    string tag;
  } exp_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       b5;
    logic       z;
    logic       mr;
    logic       rs;
  } drv_t;

  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] imm_src;
  logic [3:0] alu_control;
  logic       illegal;

  exp_t exp_q[$];
  drv_t drv_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  ctl_t       ev;
  ctl_t       em;
  string      tg;
  logic [6:0] c_op;
  logic [2:0] c_f3;
  logic       c_b5;
  logic       c_z;

  multicycle_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .op          (op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .pc_write    (pc_write),
    .adr_src     (adr_src),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .reg_write   (reg_write),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .imm_src     (imm_src),
    .alu_control (alu_control),
    .illegal     (illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic bit legal(input logic [6:0] o);
    return o == LD || o == ST || o == RT || o == IT ||
           o == BR || o == JL || o == JR || o == LU;
  endfunction

  function automatic int exp_imm(input logic [6:0] o);
    if (o == ST) return 1;
    if (o == BR) return 2;
    if (o == LU) return 3;
    if (o == JL) return 4;
    if (o == LD || o == IT || o == JR) return 0;
    return -1;
  endfunction

  function automatic int ref_alu(input logic [2:0] f, input logic b,
                                 input bit r);
    int t[8];
    t = '{A_ADD, A_SLL, A_ADD, A_ADD, A_XOR, A_SRL, A_OR, A_AND};
    if (f == 3'd0 && r && b) return A_SUB;
    return t[f];
  endfunction

  task automatic beg(input string t);
    ev = '0;
    em = '0;
    em.pcw = 1'b1;
    em.irw = 1'b1;
    em.rw  = 1'b1;
    em.mw  = 1'b1;
    em.ill = 1'b1;
    tg = t;
  endtask

  task automatic sel(input int a, input int b, input int r, input int al);
    if (a >= 0) begin ev.sa = 2'(a); em.sa = '1; end
    if (b >= 0) begin ev.sb = 2'(b); em.sb = '1; end
    if (r >= 0) begin ev.res = 2'(r); em.res = '1; end
    if (al >= 0) begin ev.alu = 4'(al); em.alu = '1; end
  endtask

  task automatic set_imm(input int i);
    ev.imm = 3'(i);
    em.imm = '1;
  endtask

  task automatic set_adr(input bit a);
    ev.adr = a;
    em.adr = 1'b1;
  endtask

  task automatic emit(input bit mr, input bit rs);
    drv_t d;
    exp_t e;
    d.op = c_op; d.f3 = c_f3; d.b5 = c_b5; d.z = c_z;
    d.mr = mr; d.rs = rs;
    e.v = ev; e.m = em; e.tag = tg;
    drv_q.push_back(d);
    exp_q.push_back(e);
  endtask

  task automatic rst_rec();
    beg("RESET");
    em = '1;
    emit(rb(), 1'b1);
  endtask

  task automatic aluwb();
    beg("ALUWB");
    sel(-1, -1, 0, -1);
    ev.rw = 1'b1;
    emit(rb(), 1'b0);
  endtask

  task automatic link(input string t);
    beg(t);
    sel(1, 2, 0, A_ADD);
    ev.pcw = 1'b1;
    emit(rb(), 1'b0);
  endtask

  // expected cycle trace of one instruction, from the instruction rules
  task automatic instr(input logic [6:0] o, input logic [2:0] f,
                       input logic b, input logic z,
                       input int fw, input int mw, input bit cut);
    int ie;
    c_op = o; c_f3 = f; c_b5 = b; c_z = z;
    for (int i = 0; i <= fw; i++) begin
      beg("FETCH");
      sel(0, 2, 2, A_ADD);
      set_adr(1'b0);
      if (i == fw) begin ev.irw = 1'b1; ev.pcw = 1'b1; end
      emit(i == fw, 1'b0);
    end
    beg("DECODE");
    sel(1, 1, -1, A_ADD);
    ie = exp_imm(o);
    if (ie >= 0) set_imm(ie);
    emit(rb(), 1'b0);
    if (o == LD) begin
      beg("MEMADR"); sel(2, 1, -1, A_ADD); emit(rb(), 1'b0);
      for (int i = 0; i <= mw; i++) begin
        beg("MEMREAD"); set_adr(1'b1); emit(i == mw, 1'b0);
      end
      beg("MEMWB"); sel(-1, 3, 2, A_LBU); ev.rw = 1'b1; emit(rb(), 1'b0);
    end else if (o == ST) begin
      beg("MEMADR"); sel(2, 1, -1, A_SB); emit(rb(), 1'b0);
      if (cut) begin
        beg("MEMWRITE"); set_adr(1'b1); ev.mw = 1'b1; emit(1'b0, 1'b0);
        rst_rec();
      end else begin
        for (int i = 0; i <= mw; i++) begin
          beg("MEMWRITE"); set_adr(1'b1); ev.mw = 1'b1;
          emit(i == mw, 1'b0);
        end
      end
    end else if (o == RT || o == IT) begin
      beg(o == RT ? "EXECR" : "EXECI");
      sel(2, o == RT ? 0 : 1, -1, ref_alu(f, b, o == RT));
      emit(rb(), 1'b0);
      aluwb();
    end else if (o == BR) begin
      beg("BRANCH");
      sel(2, 0, 0, f == 3'd1 ? A_BNE : A_BEQ);
      ev.pcw = (f == 3'd1) ? ~z : z;
      emit(rb(), 1'b0);
    end else if (o == JL) begin
      link("JAL");
      aluwb();
    end else if (o == JR) begin
      beg("JALR"); sel(2, 1, -1, A_JALR); set_imm(0); emit(rb(), 1'b0);
      link("JALRPC");
      aluwb();
    end else if (o == LU) begin
      beg("LUI"); sel(-1, 1, -1, A_LUI); set_imm(3); emit(rb(), 1'b0);
      aluwb();
    end else begin
`ifdef ILLEGAL_TRAP_EN
      for (int i = 0; i < 10; i++) begin
        beg("ERROR"); ev.ill = 1'b1; emit(rb(), 1'b0);
      end
      rst_rec();
`endif
    end
  endtask

  task automatic build();
    logic [6:0] o;
    logic [2:0] f;
    int k;
    c_op = 7'd0; c_f3 = 3'd0; c_b5 = 1'b0; c_z = 1'b0;
    rst_rec();
    rst_rec();
    instr(RT, 3'd0, 1'b0, 1'b0, 0, 0, 1'b0);
    instr(RT, 3'd0, 1'b1, 1'b0, 0, 0, 1'b0);
    instr(IT, 3'd5, 1'b0, 1'b0, 0, 0, 1'b0);
    instr(BR, 3'd0, 1'b0, 1'b1, 0, 0, 1'b0);
    instr(BR, 3'd1, 1'b0, 1'b1, 0, 0, 1'b0);
    instr(LD, 3'd4, 1'b0, 1'b0, 0, 3, 1'b0);
    instr(JR, 3'd0, 1'b0, 1'b0, 0, 0, 1'b0);
    instr(7'd0, 3'd0, 1'b0, 1'b0, 0, 0, 1'b0);
    instr(ST, 3'd0, 1'b0, 1'b0, 1, 2, 1'b1);
    instr(JL, 3'd0, 1'b0, 1'b0, 2, 0, 1'b0);
    instr(LU, 3'd0, 1'b0, 1'b0, 0, 0, 1'b0);
    instr(ST, 3'd0, 1'b0, 1'b0, 0, 2, 1'b0);
    for (int n = 0; n < 150; n++) begin
      k = $urandom_range(0, 8);
      f = 3'($urandom_range(0, 7));
      case (k)
        0: o = LD;
        1: o = ST;
        2: o = RT;
        3: o = IT;
        4: begin o = BR; f = {2'b00, f[0]}; end
        5: o = JL;
        6: o = JR;
        7: o = LU;
        default: begin
          o = 7'($urandom_range(0, 127));
          while (legal(o)) o = 7'($urandom_range(0, 127));
        end
      endcase
      instr(o, f, rb(), rb(), $urandom_range(0, 2),
            $urandom_range(0, 3), 1'b0);
    end
  endtask

  // monitor: one control word per cycle, checked against the queue
  always @(negedge clk) begin
    exp_t e;
    ctl_t act;
    logic [18:0] av, vv, mv;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act.pcw = pc_write;   act.irw = ir_write;
      act.rw  = reg_write;  act.mw  = mem_write;
      act.adr = adr_src;    act.res = result_src;
      act.sa  = alu_src_a;  act.sb  = alu_src_b;
      act.imm = imm_src;    act.alu = alu_control;
      act.ill = illegal;
      av = act; vv = e.v; mv = e.m;
      checks++;
      if ((av & mv) != (vv & mv)) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h want %h (mask %h)",
                 e.tag, cyc, av, vv, mv);
      end
      cyc++;
    end
  end

  initial begin
    drv_t d;
    rst = 1'b1;
    op = 7'd0;
    funct3 = 3'd0;
    funct7b5 = 1'b0;
    zero = 1'b0;
    mem_ready = 1'b0;
    build();
    while (drv_q.size() > 0) begin
      @(posedge clk);
      #1;
      d = drv_q.pop_front();
      rst = d.rs;
      op = d.op;
      funct3 = d.f3;
      funct7b5 = d.b5;
      zero = d.z;
      mem_ready = d.mr;
    end
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not end, got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
